// File: rtl/div_unit_pkg.sv
// Shared definitions for the integer divide functional unit.
package div_unit_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_IDX_W = 3;
  localparam int PREG_W    = 7;

  // Bit position of the divider within the EX_ready vector.
  localparam int FU_DIV_IDX = 3;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  function automatic logic f3_is_signed(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/div_unit_core.sv
// Radix-2 restoring divider datapath on unsigned magnitudes; one bit per cycle.
module div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  logic             busy;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  dvsr;
  logic [XLEN:0]    rem_shift;
  logic [XLEN:0]    diff;

  // The extra top bit of diff is the borrow of the trial subtraction.
  always_comb begin
    rem_shift = {remainder, quotient[XLEN-1]};
    diff      = rem_shift - {1'b0, dvsr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      dvsr      <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      busy      <= 1'b1;
      done      <= 1'b0;
      count     <= '0;
      dvsr      <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (busy) begin
      if (diff[XLEN]) begin
        remainder <= rem_shift[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b0};
      end else begin
        remainder <= diff[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b1};
      end
      count <= count + 1'b1;
      if (count == LAST) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/div_unit.sv
// EX-stage divide unit: tag latching, special cases, sign fix-up, flush and writeback handshake.
module div_unit #(
  parameter int XLEN      = div_unit_pkg::XLEN,
  parameter int ROB_DEPTH = div_unit_pkg::ROB_DEPTH,
  parameter int ROB_IDX_W = div_unit_pkg::ROB_IDX_W,
  parameter int PREG_W    = div_unit_pkg::PREG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [XLEN-1:0]      in_rs1_data,
  input  logic [XLEN-1:0]      in_rs2_data,
  input  logic [2:0]           in_f3,
  input  logic [PREG_W-1:0]    in_rd,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  output logic                 ready,
  output logic                 out_valid,
  output logic [XLEN-1:0]      out_data,
  output logic [PREG_W-1:0]    out_rd,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  input  logic                 out_ready,
  input  logic                 mispredict,
  input  logic [ROB_DEPTH-1:0] flush_mask
);

  import div_unit_pkg::*;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic            is_rem_q, neg_quo_q, neg_rem_q;
  logic            op_signed, op_rem, accept, kill, div_zero, overflow, core_start, core_done;
  logic [XLEN-1:0] a_mag, b_mag, special_data, core_quo, core_rem, final_data;

  assign ready     = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    op_signed    = f3_is_signed(in_f3);
    op_rem       = f3_is_rem(in_f3);
    accept       = in_valid && (state == IDLE) && !(mispredict && flush_mask[in_rob_idx]);
    kill         = mispredict && flush_mask[out_rob_idx];
    div_zero     = (in_rs2_data == '0);
    overflow     = op_signed && (in_rs1_data == INT_MIN) && (in_rs2_data == '1);
    core_start   = accept && !div_zero && !overflow;
    a_mag        = (op_signed && in_rs1_data[XLEN-1]) ? -in_rs1_data : in_rs1_data;
    b_mag        = (op_signed && in_rs2_data[XLEN-1]) ? -in_rs2_data : in_rs2_data;
    special_data = div_zero ? (op_rem ? in_rs1_data : '1) : (op_rem ? '0 : INT_MIN);
    if (is_rem_q) final_data = neg_rem_q ? -core_rem : core_rem;
    else          final_data = neg_quo_q ? -core_quo : core_quo;
  end

  div_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .abort     (kill && (state == CALC)),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  // Flush of the held tag wins over both the iteration result and the writeback grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_data    <= '0;
      out_rd      <= '0;
      out_rob_idx <= '0;
      is_rem_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          out_rd      <= in_rd;
          out_rob_idx <= in_rob_idx;
          is_rem_q    <= op_rem;
          neg_quo_q   <= op_signed && (in_rs1_data[XLEN-1] ^ in_rs2_data[XLEN-1]);
          neg_rem_q   <= op_signed && in_rs1_data[XLEN-1];
          if (div_zero || overflow) begin
            out_data <= special_data;
            state    <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: if (kill) begin
          state <= IDLE;
        end else if (core_done) begin
          out_data <= final_data;
          state    <= DONE;
        end
        DONE: if (kill || out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
